// File: rtl/tile_capture_pkg.sv
// Shared encodings and helpers for the tile capture selector.
// Imported by tile_sync and tile_capture_mux.
package tile_capture_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SNAP   = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;

  typedef logic [2:0] state_t;

  localparam state_t ST_DIRECT  = 3'd0;
  localparam state_t ST_ARMED   = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_HOLD    = 3'd3;
  localparam state_t ST_SCAN    = 3'd4;

  localparam int STABLE_TRIES = 4;

  // Index width for n items; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tile_sync.sv
// WIDTH-bit, STAGES-deep flop chain bringing an asynchronous bus into clk.
// Each bit is synchronised independently.
module tile_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/tile_capture_mux.sv
// Tile output selector: direct select, all-channel snapshot or round-robin scan.
// Define TILE_CAPTURE_STABLE_EN for multi-sample stable capture with sticky err_o.
module tile_capture_mux
  import tile_capture_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 8,
  parameter int SCAN_DWELL  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SEL_W       = sel_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [1:0]               mode_i,
  input  logic                     trig_i,
  output logic [DATA_W-1:0]        data_o,
  output logic [SEL_W-1:0]         ch_o,
  output logic                     valid_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int CNT_W = sel_width(SCAN_DWELL);

  logic [DATA_W-1:0] sync_data [NUM_CH];
  logic [DATA_W-1:0] hold_q    [NUM_CH];
  logic              trig_s;
  logic              trig_d;
  logic              trig_pulse;
  state_t            state;
  state_t            ns;
  logic [SEL_W-1:0]  scan_ch;
  logic [CNT_W-1:0]  dwell;
  logic              sel_ok;
  logic              in_snap;
  logic              cap_active;
  logic              cap_done;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_sync
    tile_sync #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ch_data_i[k*DATA_W +: DATA_W]),
      .q     (sync_data[k])
    );
  end

  tile_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_trig_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (trig_i),
    .q     (trig_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig_d <= 1'b0;
    else        trig_d <= trig_s;
  end

  assign trig_pulse = trig_s & ~trig_d;
  assign sel_ok     = int'(sel_i) < NUM_CH;
  assign in_snap    = state inside {ST_ARMED, ST_CAPTURE, ST_HOLD};
  // A mode change away from snapshot aborts the capture before any hold write.
  assign cap_active = (state == ST_CAPTURE) && (mode_i == MODE_SNAP);

`ifdef TILE_CAPTURE_STABLE_EN
  logic [2:0]        cap_idx;
  logic [DATA_W-1:0] prev_q [NUM_CH];
  logic [NUM_CH-1:0] acc_q;
  logic [NUM_CH-1:0] match;
  logic              last_try;
  logic              err_q;

  always_comb begin
    match = acc_q;
    for (int k = 0; k < NUM_CH; k++)
      if (sync_data[k] == prev_q[k]) match[k] = 1'b1;
  end

  // Cycle 0 of CAPTURE takes the first sample; cycles 1..STABLE_TRIES compare.
  assign last_try = (cap_idx == 3'(STABLE_TRIES));
  assign cap_done = (cap_idx != 3'd0) && ((&match) || last_try);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_idx <= 3'd0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) prev_q[k] <= '0;
    end else begin
      cap_idx <= (cap_active && !cap_done) ? cap_idx + 3'd1 : 3'd0;
      if (cap_active) begin
        for (int k = 0; k < NUM_CH; k++) prev_q[k] <= sync_data[k];
        acc_q <= (cap_idx == 3'd0) ? '0 : match;
        if (last_try && !(&match)) err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign cap_done = 1'b1;
  assign err_o    = 1'b0;
`endif

  // NOTE: hold registers are a handful of flops, not a RAM, and must read as
  // zero after reset, so they take the async reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) hold_q[k] <= '0;
    end else if (cap_active) begin
      for (int k = 0; k < NUM_CH; k++) begin
`ifdef TILE_CAPTURE_STABLE_EN
        if ((cap_idx != 3'd0) && !acc_q[k] && (match[k] || last_try))
          hold_q[k] <= sync_data[k];
`else
        hold_q[k] <= sync_data[k];
`endif
      end
    end
  end

  // NOTE: ns gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    ns = state;
    case (mode_i)
      MODE_SNAP: begin
        if (!in_snap)                 ns = ST_ARMED;
        else if (state == ST_CAPTURE) ns = cap_done ? ST_HOLD : ST_CAPTURE;
        else if (trig_pulse)          ns = ST_CAPTURE;
      end
      MODE_SCAN: ns = ST_SCAN;
      default:   ns = ST_DIRECT;
    endcase
  end

  // Outputs are computed for the state being entered, so a mode change
  // shows its new behaviour on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_DIRECT;
      data_o  <= '0;
      ch_o    <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      scan_ch <= '0;
      dwell   <= '0;
    end else begin
      state   <= ns;
      busy_o  <= (ns == ST_CAPTURE) || (ns == ST_SCAN);
      valid_o <= 1'b0;
      case (ns)
        ST_DIRECT: begin
          data_o  <= sel_ok ? sync_data[sel_i] : '0;
          ch_o    <= sel_i;
          valid_o <= sel_ok;
        end
        ST_HOLD: begin
          if (state == ST_HOLD) begin
            data_o  <= sel_ok ? hold_q[sel_i] : '0;
            ch_o    <= sel_i;
            valid_o <= sel_ok;
          end
        end
        ST_SCAN: begin
          if (state != ST_SCAN) begin
            scan_ch <= '0;
            dwell   <= '0;
          end else if (dwell == CNT_W'(SCAN_DWELL - 1)) begin
            data_o  <= sync_data[scan_ch];
            ch_o    <= scan_ch;
            valid_o <= 1'b1;
            scan_ch <= (scan_ch == SEL_W'(NUM_CH - 1)) ? '0 : scan_ch + SEL_W'(1);
            dwell   <= '0;
          end else begin
            dwell <= dwell + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_capture_mux.sv
// Self-checking bench for tile_capture_mux: directed steps plus random stimulus
// against a delay-line / snapshot / scan-schedule reference model.
module tb_tile_capture_mux;

  localparam int NUM_CH      = 4;
  localparam int DATA_W      = 8;
  localparam int SCAN_DWELL  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int SEL_W       = 2;
`ifdef TILE_CAPTURE_STABLE_EN
  localparam int CAP_CYC  = 2;
  localparam int EXP_BUSY = 5;
  localparam int EXP_ERR  = 1;
`else
  localparam int CAP_CYC  = 1;
  localparam int EXP_BUSY = 1;
  localparam int EXP_ERR  = 0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;
  logic [SEL_W-1:0]         sel = '0;
  logic [1:0]               mode = 2'b00;
  logic                     trig = 1'b0;
  logic [DATA_W-1:0]        data_o;
  logic [SEL_W-1:0]         ch_o;
  logic                     valid_o;
  logic                     busy_o;
  logic                     err_o;

  int total = 0;
  int bad   = 0;
  logic [NUM_CH*DATA_W-1:0] hist [$];

  always #5 clk = ~clk;

  tile_capture_mux #(
    .NUM_CH      (NUM_CH),
    .DATA_W      (DATA_W),
    .SCAN_DWELL  (SCAN_DWELL),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_data_i (ch_data),
    .sel_i     (sel),
    .mode_i    (mode),
    .trig_i    (trig),
    .data_o    (data_o),
    .ch_o      (ch_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; records the channel vector the DUT sampled at this edge.
  task automatic tick();
    @(posedge clk);
    hist.push_back(ch_data);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] chan(input logic [NUM_CH*DATA_W-1:0] v, input int k);
    return v[k*DATA_W +: DATA_W];
  endfunction

  // Direct mode: data_o shows the channel as sampled SYNC_STAGES edges ago.
  function automatic logic [DATA_W-1:0] exp_direct();
    return chan(hist[hist.size() - 1 - SYNC_STAGES], int'(sel));
  endfunction

  initial begin
    logic [DATA_W-1:0]        held;
    logic [NUM_CH*DATA_W-1:0] vec;
    int                       pulses;
    int                       busy_cnt;

    // Reset state
    repeat (3) tick();
    check("rst_data", data_o, 0);
    check("rst_ch", ch_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    rst_n = 1'b1;
    tick();

    // Direct latency and mode 11 alias
    sel = 2'd2;
    repeat (4) tick();
    ch_data[2*DATA_W +: DATA_W] = 8'hA5;
    repeat (2) tick();
    check("direct_early", data_o, 8'h00);
    tick();
    check("direct_data", data_o, 8'hA5);
    check("direct_ch", ch_o, 2);
    check("direct_valid", valid_o, 1);
    check("direct_busy", busy_o, 0);
    mode = 2'b11;
    ch_data[2*DATA_W +: DATA_W] = 8'h5A;
    repeat (3) tick();
    check("mode11_data", data_o, 8'h5A);
    check("mode11_valid", valid_o, 1);

    // Random direct traffic against the delay-line model
    for (int i = 0; i < 40; i++) begin
      ch_data = $urandom();
      sel     = SEL_W'($urandom_range(NUM_CH - 1, 0));
      mode    = ($urandom_range(1, 0) != 0) ? 2'b11 : 2'b00;
      tick();
      check("rand_direct_data", data_o, exp_direct());
      check("rand_direct_ch", ch_o, sel);
      check("rand_direct_valid", valid_o, 1);
    end

    // Snapshot
    mode    = 2'b00;
    ch_data = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (4) tick();
    held = exp_direct();
    mode = 2'b01;
    tick();
    check("armed_valid", valid_o, 0);
    check("armed_busy", busy_o, 0);
    check("armed_hold_data", data_o, held);
    tick();
    trig = 1'b1;
    repeat (2) tick();
    check("armed_wait_busy", busy_o, 0);
    tick();
    check("capture_busy", busy_o, 1);
    ch_data[1*DATA_W +: DATA_W] = 8'hFF;
    repeat (CAP_CYC) tick();
    check("hold_first_busy", busy_o, 0);
    check("hold_first_valid", valid_o, 0);
    for (int k = 0; k < NUM_CH; k++) begin
      sel = SEL_W'(k);
      tick();
      check("hold_sweep_data", data_o, 8'h11 * (k + 1));
      check("hold_sweep_ch", ch_o, k);
      check("hold_sweep_valid", valid_o, 1);
    end
    sel = 2'd1;
    repeat (3) tick();
    check("hold_no_retrig", data_o, 8'h22);

    // Retrigger from HOLD overwrites the snapshot
    trig = 1'b0;
    repeat (3) tick();
    trig = 1'b1;
    repeat (4 + CAP_CYC) tick();
    check("recapture_data", data_o, 8'hFF);
    check("recapture_valid", valid_o, 1);

    // Re-arming keeps valid low until a new capture
    mode = 2'b00;
    tick();
    mode = 2'b01;
    tick();
    check("rearm_valid", valid_o, 0);
    repeat (3) tick();
    check("rearm_valid_stays", valid_o, 0);

    // Mode change mid-capture
    trig = 1'b0;
    repeat (3) tick();
    trig = 1'b1;
    repeat (3) tick();
    check("abort_cap_busy_in", busy_o, 1);
    mode = 2'b00;
    tick();
    check("abort_cap_busy", busy_o, 0);
    check("abort_cap_valid", valid_o, 1);
    check("abort_cap_data", data_o, exp_direct());
    trig = 1'b0;

    // Scan wrap over static random channels
    vec     = $urandom();
    ch_data = vec;
    repeat (3) tick();
    mode = 2'b10;
    tick();
    check("scan_entry_busy", busy_o, 1);
    check("scan_entry_valid", valid_o, 0);
    pulses = 0;
    for (int t = 1; t <= NUM_CH * SCAN_DWELL + SCAN_DWELL; t++) begin
      tick();
      check("scan_valid", valid_o, ((t % SCAN_DWELL) == 0) ? 1 : 0);
      check("scan_busy", busy_o, 1);
      if ((t % SCAN_DWELL) == 0) begin
        check("scan_ch", ch_o, pulses % NUM_CH);
        check("scan_data", data_o, chan(vec, pulses % NUM_CH));
        pulses++;
      end
    end
    check("scan_pulse_count", pulses, NUM_CH + 1);

    // Mode change mid-scan at dwell count 2
    mode = 2'b00;
    tick();
    mode = 2'b10;
    tick();
    repeat (2) tick();
    mode = 2'b00;
    tick();
    check("abort_scan_busy", busy_o, 0);
    check("abort_scan_valid", valid_o, 1);
    check("abort_scan_ch", ch_o, sel);
    check("abort_scan_data", data_o, exp_direct());
    repeat (4) tick();
    check("abort_scan_stays_direct", ch_o, sel);

    // Capture while ch0 toggles every cycle
    mode = 2'b01;
    tick();
    vec     = $urandom();
    ch_data = vec;
    repeat (3) tick();
    busy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      ch_data[DATA_W-1:0] = ~ch_data[DATA_W-1:0];
      if (i == 1) trig = 1'b1;
      tick();
      if (busy_o) busy_cnt++;
    end
    check("toggle_busy_cycles", busy_cnt, EXP_BUSY);
    check("toggle_err", err_o, EXP_ERR);
    trig = 1'b0;
    for (int k = 1; k < NUM_CH; k++) begin
      sel = SEL_W'(k);
      tick();
      check("toggle_stable_ch", data_o, chan(vec, k));
    end
    repeat (3) tick();
    check("toggle_err_sticky", err_o, EXP_ERR);

    // Asynchronous reset in the middle of a scan
    mode = 2'b10;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_data", data_o, 0);
    check("midrst_ch", ch_o, 0);
    check("midrst_valid", valid_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_err", err_o, 0);
    mode = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", valid_o, 1);
    check("post_rst_busy", busy_o, 0);
    check("post_rst_data", data_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tile_capture_mux.md
Name: tile_capture_mux

Overview:
Parametrised successor to the fixed 4-way micro-tile output selector. Takes NUM_CH sensor/TDC/ring-oscillator result buses and synchronises each into the clk domain. Delivers one channel to the tile output in one of three modes: direct select, simultaneous snapshot of all channels, or automatic round-robin scan with a programmable dwell.

Parameters:
NUM_CH, 4, number of input channels (>=2)
DATA_W, 8, width of each channel bus and of data_o
SCAN_DWELL, 16, clk cycles spent on each channel in scan mode (>=1)
SYNC_STAGES, 2, synchroniser flop depth for channel data and trig_i (>=2)

Ports:
clk  in  1  system clock; the only clock
rst_n  in  1  reset, asynchronous assert, active-low
ch_data_i  in  NUM_CH*DATA_W  channel buses, channel k at bits [k*DATA_W +: DATA_W]; asynchronous to clk
sel_i  in  SEL_W=$clog2(NUM_CH)  channel select for direct and snapshot modes
mode_i  in  2  00 direct, 01 snapshot, 10 scan, 11 treated as direct
trig_i  in  1  snapshot trigger, asynchronous, rising-edge active
data_o  out  DATA_W  selected/captured channel data, registered
ch_o  out  SEL_W  channel index of data_o
valid_o  out  1  data_o qualifier (see per mode)
busy_o  out  1  capture or scan in progress
err_o  out  1  sticky stability error (optional feature only)

Behaviour:
- One clock, clk. rst_n asynchronous, active-low. During reset: all synchroniser flops, hold registers, counters, data_o, ch_o, valid_o, busy_o and err_o are 0; state DIRECT.
- sync[k]: ch_data_i slice k after SYNC_STAGES flops. Bits are synchronised independently; multi-bit coherence is the source's responsibility, or is handled by the optional feature.
- trig_i: passes through SYNC_STAGES flops plus one edge-detect flop; trig_pulse is high for one cycle per rising edge.
- FSM states: DIRECT, ARMED, CAPTURE, HOLD, SCAN. mode_i is sampled every cycle and a change takes effect on the next edge from any state (aborts a capture or scan in progress). Mode 00/11 goes to DIRECT, 01 to ARMED, 10 to SCAN.
- DIRECT:
  - data_o <= sync[sel_i]; ch_o <= sel_i; valid_o=1.
  - Latency from ch_data_i to data_o: SYNC_STAGES+1 cycles.
  - If sel_i >= NUM_CH: data_o <= 0 and valid_o=0.
- ARMED:
  - data_o and ch_o hold their last value; valid_o=0; busy_o=0.
  - trig_pulse goes to CAPTURE.
- CAPTURE (1 cycle, unless the optional feature is enabled):
  - hold[k] <= sync[k] for all k in the same cycle; busy_o=1; then go to HOLD.
- HOLD:
  - data_o <= hold[sel_i] (follows sel_i with 1-cycle latency); ch_o <= sel_i; valid_o=1; busy_o=0.
  - If sel_i >= NUM_CH: data_o <= 0 and valid_o=0.
  - trig_pulse goes to CAPTURE and overwrites hold; trig_pulse in CAPTURE is ignored.
- SCAN:
  - On entry, ch=0 and dwell counter=0; busy_o=1.
  - The counter counts 0..SCAN_DWELL-1. At terminal count: data_o <= sync[ch]; ch_o <= ch; valid_o=1 for exactly one cycle; ch <= (ch==NUM_CH-1) ? 0 : ch+1; counter <= 0.
  - First valid_o occurs SCAN_DWELL cycles after entry.
  - With SCAN_DWELL=1, valid_o stays high continuously and ch advances every cycle.
- Hold registers persist across mode changes; they are cleared only by reset.
- Re-entering ARMED after HOLD keeps the old hold contents, but valid_o stays 0 until a new capture.

Optional Feature:
Macro TILE_CAPTURE_STABLE_EN.
- Defined:
  - CAPTURE samples every channel on consecutive cycles and accepts a channel once two consecutive samples are equal.
  - Up to 4 attempts (max 5 cycles in CAPTURE). Channels still unstable after 4 attempts take the last sample and set err_o, which is sticky until reset.
  - busy_o stays high for the whole of CAPTURE.
- Not defined: single-cycle CAPTURE; err_o is tied to 0.

Decomposition:
- Package tile_capture_pkg:
  - mode encodings (MODE_DIRECT, MODE_SNAP, MODE_SCAN);
  - FSM state enum;
  - STABLE_TRIES=4 constant;
  - sel-width helper function.
- One sub-module: tile_sync, a parametrised WIDTH x SYNC_STAGES flop chain with async active-low reset. Instantiated per channel and for trig_i.

Test Plan (NUM_CH=4, DATA_W=8, SCAN_DWELL=4, SYNC_STAGES=2):
- Reset mid-scan: assert rst_n=0 at any cycle -> data_o=0, ch_o=0, valid_o=0, busy_o=0, err_o=0 immediately (async); state DIRECT after release.
- Direct: ch2=0xA5, sel_i=2, mode 00 -> data_o=0xA5, ch_o=2 three cycles after the data change; mode 11 behaves identically.
- Snapshot: channels 0x11/0x22/0x33/0x44, mode 01, pulse trig_i, then change ch1 to 0xFF -> data_o=0x22 for sel_i=1; sweeping sel_i 0..3 returns 0x11..0x44; valid_o=1 in HOLD.
- Scan wrap: mode 10, static channels 0x11..0x44 -> valid_o one-cycle pulses every 4 cycles, ch_o 0,1,2,3,0; data_o matches each channel.
- Mode change mid-capture and mid-scan: switch 10->00 at dwell count 2 -> no further valid_o pulse; DIRECT output on the next edge; busy_o=0.
- With TILE_CAPTURE_STABLE_EN: toggle ch0 every cycle during capture -> busy_o high 5 cycles, err_o=1 and sticky; stable channels capture correctly.
